// File: rtl/axis_packet_joiner.sv
// Packet-granular round-robin AXIS joiner with per-beat source tagging on tdest.
// Optional macro AXIS_JOINER_SKIP_IDLE_EN: skip streams with no data at packet boundaries.
`timescale 1ns/1ps

module axis_packet_joiner #(
    parameter int AXIS_BYTES     = 4,
    parameter int AXIS_USER_BITS = 1,
    parameter int NUM_STREAMS    = 4,
    parameter int DEST_BITS      = 4,
    parameter int TDEST_BASE     = 0,
    parameter int TLAST_MODE     = 0,
    parameter int CNT_BITS       = 16
) (
    input  logic                                    clk,
    input  logic                                    sresetn,
    input  logic                                    enable,
    input  logic [CNT_BITS-1:0]                     frame_packets,
    input  logic [NUM_STREAMS*8*AXIS_BYTES-1:0]     s_axis_tdata,
    input  logic [NUM_STREAMS*AXIS_BYTES-1:0]       s_axis_tkeep,
    input  logic [NUM_STREAMS*AXIS_USER_BITS-1:0]   s_axis_tuser,
    input  logic [NUM_STREAMS-1:0]                  s_axis_tvalid,
    input  logic [NUM_STREAMS-1:0]                  s_axis_tlast,
    output logic [NUM_STREAMS-1:0]                  s_axis_tready,
    output logic [8*AXIS_BYTES-1:0]                 m_axis_tdata,
    output logic [AXIS_BYTES-1:0]                   m_axis_tkeep,
    output logic [AXIS_USER_BITS-1:0]               m_axis_tuser,
    output logic                                    m_axis_tvalid,
    output logic                                    m_axis_tlast,
    input  logic                                    m_axis_tready,
    output logic [DEST_BITS-1:0]                    m_axis_tdest,
    output logic                                    busy,
    output logic                                    frame_done,
    output logic [CNT_BITS-1:0]                     frame_count
);

    localparam int DW       = 8 * AXIS_BYTES;
    localparam int SEL_BITS = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t                r_state;
    logic [SEL_BITS-1:0]   r_sel;
    logic [CNT_BITS-1:0]   r_pkt_cnt;
    logic [CNT_BITS-1:0]   r_frame_pkts;
    logic [CNT_BITS-1:0]   r_frame_count;
    logic                  r_busy;
    logic                  r_frame_done;

    logic [SEL_BITS-1:0]   w_sel;
    logic [SEL_BITS-1:0]   w_sel_next;
    logic                  w_send;
    logic                  w_beat;
    logic                  w_tlast_in;
    logic                  w_last_pkt;

    logic [DW-1:0]             w_data [NUM_STREAMS];
    logic [AXIS_BYTES-1:0]     w_keep [NUM_STREAMS];
    logic [AXIS_USER_BITS-1:0] w_user [NUM_STREAMS];

    for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_slice
        assign w_data[gi] = s_axis_tdata[gi*DW +: DW];
        assign w_keep[gi] = s_axis_tkeep[gi*AXIS_BYTES +: AXIS_BYTES];
        assign w_user[gi] = s_axis_tuser[gi*AXIS_USER_BITS +: AXIS_USER_BITS];
    end

`ifdef AXIS_JOINER_SKIP_IDLE_EN
    logic                r_locked;
    logic [SEL_BITS-1:0] w_sel_hunt;

    // Descending scan so the nearest valid stream after the nominal index wins.
    always_comb begin
        int                  idx;
        logic [SEL_BITS-1:0] cand;
        w_sel_hunt = r_sel;
        for (int k = NUM_STREAMS - 1; k >= 0; k--) begin
            idx = int'(r_sel) + k;
            if (idx >= NUM_STREAMS) idx = idx - NUM_STREAMS;
            cand = SEL_BITS'(idx);
            if (s_axis_tvalid[cand]) w_sel_hunt = cand;
        end
    end

    assign w_sel = r_locked ? r_sel : w_sel_hunt;
`else
    assign w_sel = r_sel;
`endif

    assign w_sel_next = (w_sel == SEL_BITS'(NUM_STREAMS - 1)) ? '0 : w_sel + 1'b1;
    assign w_send     = (r_state == ST_SEND);
    assign w_tlast_in = s_axis_tlast[w_sel];
    assign w_last_pkt = (r_frame_pkts != '0) &&
                        (r_pkt_cnt == r_frame_pkts - CNT_BITS'(1));

    assign m_axis_tvalid = w_send && s_axis_tvalid[w_sel];
    assign s_axis_tready = w_send ? (NUM_STREAMS'(m_axis_tready) << w_sel) : '0;
    assign w_beat        = m_axis_tvalid && m_axis_tready;

    assign m_axis_tdata  = w_data[w_sel];
    assign m_axis_tkeep  = w_keep[w_sel];
    assign m_axis_tuser  = w_user[w_sel];
    assign m_axis_tdest  = DEST_BITS'(TDEST_BASE) + DEST_BITS'(w_sel);
    assign m_axis_tlast  = w_send && w_tlast_in &&
                           ((TLAST_MODE == 0) || w_last_pkt);

    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            r_state       <= ST_IDLE;
            r_sel         <= '0;
            r_pkt_cnt     <= '0;
            r_frame_pkts  <= '0;
            r_frame_count <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
`ifdef AXIS_JOINER_SKIP_IDLE_EN
            r_locked      <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state      <= ST_SEND;
                        r_busy       <= 1'b1;
                        r_frame_pkts <= frame_packets;
                        r_sel        <= '0;
                        r_pkt_cnt    <= '0;
`ifdef AXIS_JOINER_SKIP_IDLE_EN
                        r_locked     <= 1'b0;
`endif
                    end
                end
                ST_SEND: begin
                    if (w_beat && w_tlast_in) begin
                        r_sel     <= w_sel_next;
                        r_pkt_cnt <= r_pkt_cnt + CNT_BITS'(1);
`ifdef AXIS_JOINER_SKIP_IDLE_EN
                        r_locked  <= 1'b0;
`endif
                        // Frame completion wins over a concurrent disarm.
                        if (w_last_pkt) begin
                            r_state       <= ST_DONE;
                            r_busy        <= 1'b0;
                            r_frame_done  <= 1'b1;
                            r_frame_count <= r_frame_count + CNT_BITS'(1);
                        end else if (!enable) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_beat) begin
                        r_sel    <= w_sel;
`ifdef AXIS_JOINER_SKIP_IDLE_EN
                        r_locked <= 1'b1;
`endif
                    end
                end
                ST_DONE: begin
                    if (!enable) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_packet_joiner.sv
// Directed bench for axis_packet_joiner; a TLAST_MODE=1 twin runs in lockstep.
// Sources emit {stream, packet, beat, A5} words so order and loss are visible.
`timescale 1ns/1ps

module tb_axis_packet_joiner;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            sresetn;
    logic            enable;
    logic [15:0]     frame_packets;
    logic [N*32-1:0] s_tdata;
    logic [N*4-1:0]  s_tkeep;
    logic [N-1:0]    s_tuser;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [31:0]     m_tdata;
    logic [3:0]      m_tkeep;
    logic [0:0]      m_tuser;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready;
    logic [3:0]      m_tdest;
    logic            busy;
    logic            frame_done;
    logic [15:0]     frame_count;

    logic [N-1:0]    s1_tready;
    logic [31:0]     m1_tdata;
    logic [3:0]      m1_tkeep;
    logic [0:0]      m1_tuser;
    logic            m1_tvalid;
    logic            m1_tlast;
    logic [3:0]      m1_tdest;
    logic            busy1;
    logic            frame_done1;
    logic [15:0]     frame_count1;

    axis_packet_joiner u_dut (
        .clk(clk), .sresetn(sresetn), .enable(enable),
        .frame_packets(frame_packets),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
        .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .m_axis_tdest(m_tdest), .busy(busy),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    axis_packet_joiner #(.TLAST_MODE(1)) u_dut1 (
        .clk(clk), .sresetn(sresetn), .enable(enable),
        .frame_packets(frame_packets),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s1_tready),
        .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep),
        .m_axis_tuser(m1_tuser), .m_axis_tvalid(m1_tvalid),
        .m_axis_tlast(m1_tlast), .m_axis_tready(m_tready),
        .m_axis_tdest(m1_tdest), .busy(busy1),
        .frame_done(frame_done1), .frame_count(frame_count1)
    );

    int n_chk = 0;
    int n_fail = 0;
    int nbeats, npulse, pulse_at, bad, plen;
    bit rnd;
    int src_beat [N];
    int src_pkt  [N];
    logic [N-1:0] src_en;
    logic [63:0]  q_rec [$];
    logic         q_l1  [$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_test(input int len);
        q_rec.delete();
        q_l1.delete();
        nbeats = 0; npulse = 0; pulse_at = -1; bad = 0; plen = len;
        for (int i = 0; i < N; i++) begin
            src_beat[i] = 0;
            src_pkt[i]  = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]        = src_en[i];
            s_tlast[i]         = (src_beat[i] == plen - 1);
            s_tdata[i*32 +: 32] = {8'(i), 8'(src_pkt[i]), 8'(src_beat[i]), 8'hA5};
            s_tkeep[i*4 +: 4]  = 4'(i) | 4'h8;
            s_tuser[i]         = (src_beat[i] == 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        drive();
        m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (m_tvalid && m_tready) begin
            q_rec.push_back({22'b0, m_tuser, m_tkeep, m_tlast, m_tdest, m_tdata});
            q_l1.push_back(m1_tlast);
            nbeats++;
        end
        if (frame_done) begin
            npulse++;
            pulse_at = nbeats;
        end
        for (int i = 0; i < N; i++)
            if (s_tready[i] && (!busy || !m_tready || m_tdest != 4'(i))) bad++;
        for (int i = 0; i < N; i++) begin
            if (s_tvalid[i] && s_tready[i]) begin
                if (src_beat[i] == plen - 1) begin
                    src_beat[i] = 0;
                    src_pkt[i]++;
                end else begin
                    src_beat[i]++;
                end
            end
        end
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int c = 0;
        while (nbeats < target && c < budget) begin
            tick();
            c++;
        end
        chk({tag, "_timeout"}, 64'(nbeats >= target), 64'd1);
    endtask

    function automatic logic [63:0] exp_rec(input int k);
        int s, p, b;
        s = (k / plen) % N;
        p = (k / plen) / N;
        b = k % plen;
        return {22'b0, 1'(b == 0), 4'(s) | 4'h8, 1'(b == plen - 1), 4'(s),
                8'(s), 8'(p), 8'(b), 8'hA5};
    endfunction

    task automatic chk_seq(input string tag, input int n);
        for (int k = 0; k < n && k < q_rec.size(); k++)
            chk($sformatf("%s_beat%0d", tag, k), q_rec[k], exp_rec(k));
    endtask

    function automatic logic [63:0] l1_mask();
        logic [63:0] m = '0;
        foreach (q_l1[k]) if (k < 64) m[k] = q_l1[k];
        return m;
    endfunction

`ifdef AXIS_JOINER_SKIP_IDLE_EN
    int exp5 [8] = '{0, 0, 2, 2, 3, 3, 0, 0};
`endif

    initial begin
        sresetn = 1'b0; enable = 1'b0; frame_packets = '0;
        m_tready = 1'b0; rnd = 1'b0; src_en = '1;
        start_test(3);
        repeat (3) tick();
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fdone", 64'(frame_done), 64'd0);
        chk("rst_fcount", 64'(frame_count), 64'd0);
        sresetn = 1'b1;
        tick();

        // Full frame of 8 packets, no backpressure
        start_test(3);
        frame_packets = 16'd8; enable = 1'b1;
        run_until(24, 200, "t1");
        repeat (6) tick();
        chk("t1_beats", 64'(nbeats), 64'd24);
        chk_seq("t1", 24);
        chk("t1_pulses", 64'(npulse), 64'd1);
        chk("t1_pulse_at", 64'(pulse_at), 64'd24);
        chk("t1_fcount", 64'(frame_count), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_l1mask", l1_mask(), 64'h80_0000);
        chk("t1_ready", 64'(bad), 64'd0);
        enable = 1'b0;
        repeat (3) tick();

        // 4-packet frame; frame_packets change while sending is ignored
        start_test(3);
        frame_packets = 16'd4; enable = 1'b1;
        run_until(2, 50, "t2a");
        frame_packets = 16'd1;
        run_until(12, 100, "t2");
        repeat (6) tick();
        chk("t2_beats", 64'(nbeats), 64'd12);
        chk_seq("t2", 12);
        chk("t2_l1mask", l1_mask(), 64'h800);
        chk("t2_pulse_at", 64'(pulse_at), 64'd12);
        chk("t2_fcount", 64'(frame_count), 64'd2);
        enable = 1'b0;
        repeat (3) tick();

        // Random backpressure
        start_test(3);
        rnd = 1'b1; frame_packets = 16'd8; enable = 1'b1;
        run_until(24, 400, "t3");
        repeat (6) tick();
        rnd = 1'b0;
        chk("t3_beats", 64'(nbeats), 64'd24);
        chk_seq("t3", 24);
        chk("t3_ready", 64'(bad), 64'd0);
        chk("t3_pulses", 64'(npulse), 64'd1);
        chk("t3_fcount", 64'(frame_count), 64'd3);
        enable = 1'b0;
        repeat (3) tick();

        // Unlimited frame; disarm lands on a tlast beat
        start_test(2);
        frame_packets = 16'd0; enable = 1'b1;
        run_until(20, 200, "t4u");
        enable = 1'b0;
        repeat (8) tick();
        chk("t4u_beats", 64'(nbeats), 64'd20);
        chk_seq("t4u", 20);
        chk("t4u_l1mask", l1_mask(), 64'd0);
        chk("t4u_pulses", 64'(npulse), 64'd0);
        chk("t4u_busy", 64'(busy), 64'd0);

        // Disarm on beat 2 of a 5-beat packet
        start_test(5);
        enable = 1'b1;
        run_until(2, 100, "t4");
        enable = 1'b0;
        repeat (10) tick();
        chk("t4_beats", 64'(nbeats), 64'd5);
        chk_seq("t4", 5);
        chk("t4_pulses", 64'(npulse), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_fcount", 64'(frame_count), 64'd3);

        // Stream 1 silent
        start_test(2);
        src_en = 4'b1101; enable = 1'b1;
`ifdef AXIS_JOINER_SKIP_IDLE_EN
        run_until(8, 100, "t5");
        for (int k = 0; k < 8 && k < q_rec.size(); k++)
            chk($sformatf("t5_dest%0d", k), 64'(q_rec[k][35:32]), 64'(exp5[k]));
`else
        repeat (30) tick();
        chk("t5_stall_beats", 64'(nbeats), 64'd2);
        chk("t5_dest0", 64'(q_rec[0][35:32]), 64'd0);
        chk("t5_busy", 64'(busy), 64'd1);
        src_en = 4'b1111;
        run_until(4, 50, "t5");
        chk("t5_dest2", 64'(q_rec[2][35:32]), 64'd1);
`endif
        enable = 1'b0;
        repeat (6) tick();
        src_en = 4'b1111;

        // Reset mid-packet
        start_test(4);
        enable = 1'b1;
        run_until(6, 100, "t6a");
        sresetn = 1'b0; enable = 1'b0;
        tick();
        tick();
        chk("t6_tvalid", 64'(m_tvalid), 64'd0);
        chk("t6_tready", 64'(s_tready), 64'd0);
        chk("t6_tlast", 64'(m_tlast), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_fdone", 64'(frame_done), 64'd0);
        chk("t6_fcount", 64'(frame_count), 64'd0);
        sresetn = 1'b1;
        start_test(4);
        enable = 1'b1;
        run_until(4, 50, "t6");
        chk_seq("t6", 4);
        enable = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
